// File: rtl/seq_addsub_chunked.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB chunk first,
// with the carry registered between chunks and valid/ready on both sides.
module seq_addsub_chunked #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("seq_addsub_chunked: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r;
   logic             carry_r;
   logic [CW-1:0]    cnt;

   logic [CHUNK-1:0] a_ch, b_ch, part;
   logic [CHUNK:0]   chunk_sum;
   logic             c_next, c_msb_in, last;
   logic [WIDTH-1:0] sum_nx;

   assign start_ready  = (state == IDLE);
   assign result_valid = (state == DONE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_valid)  state_nx = RUN;
         RUN:     if (last)         state_nx = DONE;
         DONE:    if (result_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Carry into the top bit of a chunk is recovered as a ^ b ^ sum at that bit.
   always_comb begin
      a_ch      = a_r[cnt*CHUNK +: CHUNK];
      b_ch      = b_r[cnt*CHUNK +: CHUNK];
      chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_r};
      part      = chunk_sum[CHUNK-1:0];
      c_next    = chunk_sum[CHUNK];
      c_msb_in  = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ part[CHUNK-1];
      last      = (cnt == CW'(NCHUNK - 1));
      sum_nx    = sum;
      sum_nx[cnt*CHUNK +: CHUNK] = part;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         carry_r   <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_r     <= a;
                  b_r     <= sub ? ~b : b;
                  carry_r <= sub ? 1'b1 : cin;
                  cnt     <= '0;
               end
            end
            RUN: begin
               sum     <= sum_nx;
               carry_r <= c_next;
               cnt     <= cnt + 1'b1;
               if (last) begin
                  carry_out <= c_next;
                  overflow  <= c_msb_in ^ c_next;
                  zero      <= (sum_nx == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Directed self-checking bench for seq_addsub_chunked (WIDTH=16, CHUNK=4).
module tb_seq_addsub_chunked;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] a, b;
   logic        cin, sub;
   logic        result_valid;
   logic        result_ready;
   logic [15:0] sum;
   logic        carry_out, overflow, zero;

   int n_cmp = 0;
   int n_err = 0;

   seq_addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .result_valid(result_valid), .result_ready(result_ready),
      .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation and wait (bounded) for result_valid.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub,
                         input logic [15:0] esum, input logic eco, input logic eov, input logic ez);
      int lat;
      @(negedge clk);
      a = ta; b = tb_; cin = tcin; sub = tsub; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin; sub = ~tsub;
      check({tag, "_busy_start_ready"}, 32'(start_ready), 32'd0);
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_sum"}, 32'(sum), 32'(esum));
      check({tag, "_carry_out"}, 32'(carry_out), 32'(eco));
      check({tag, "_overflow"}, 32'(overflow), 32'(eov));
      check({tag, "_zero"}, 32'(zero), 32'(ez));
   endtask

   task automatic finish_op(input string tag);
      @(negedge clk);
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check({tag, "_rv_after_hs"}, 32'(result_valid), 32'd0);
      check({tag, "_sr_after_hs"}, 32'(start_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #12;
      check("rst_start_ready", 32'(start_ready), 32'd1);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
      finish_op("add1");
      run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      finish_op("wrap");
      run_op("cin1", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      finish_op("cin1");
      run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      finish_op("sovf");
      run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      finish_op("sub1");
      run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

      // Backpressure: hold DONE for 3 cycles while poking start_valid.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start_valid = (i == 1); a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0;
         @(posedge clk); #1;
         start_valid = 1'b0;
         check("bp_result_valid", 32'(result_valid), 32'd1);
         check("bp_start_ready", 32'(start_ready), 32'd0);
         check("bp_sum", 32'(sum), 32'h7FFF);
         check("bp_flags", {29'd0, carry_out, overflow, zero}, 32'b110);
      end
      finish_op("bp");
      repeat (5) @(posedge clk);
      #1;
      check("bp_no_queued_op", 32'(result_valid), 32'd0);
      check("idle_holds_sum", 32'(sum), 32'h7FFF);

      // Asynchronous reset in the middle of RUN (counter = 2).
      @(negedge clk);
      a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      check("arst_result_valid", 32'(result_valid), 32'd0);
      check("arst_start_ready", 32'(start_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      finish_op("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
